// File: rtl/frame_rx.sv
// frame_rx: MK/CLK/DAT serial frame deserializer. It aligns to the frame marker and decodes
// the header and the split parameters. Define FRAME_RX_HDR_CHECK_EN to enable the word 0/10 header checks.
module frame_rx #(
  parameter int TIMEOUT = 4096,
  parameter int ERR_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MK,
  input  logic             CLK,
  input  logic             DAT,
  output logic [15:0]      word_data,
  output logic             word_valid,
  output logic [4:0]       word_idx,
  output logic [5:0]       str_num,
  output logic [8:0]       frm_num,
  output logic [55:0]      params,
  output logic             param_valid,
  output logic             locked,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt
);

  typedef enum logic {
    S_HUNT = 1'b0,
    S_LOCK = 1'b1
  } state_t;

  localparam int              TO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [2:0]        r_mk_sync;
  logic [2:0]        r_clk_sync;
  logic [2:0]        r_dat_sync;
  logic [15:0]       r_shreg;
  logic [3:0]        r_bit_cnt;
  logic [4:0]        r_widx;
  logic [5:0]        r_snum;
  logic              r_arm;
  logic [TO_W-1:0]   r_to_cnt;
  logic [55:0]       r_param_stage;
  logic              r_param_load;

  logic              w_sample;
  logic              w_mk_rise;
  logic [15:0]       w_word;
  logic              w_word_done;
  logic              w_end_pos;
  logic              w_timeout;
  logic              w_word_strobe;
  logic              w_frame_err;
  logic              w_hdr_err;

  assign w_sample    = r_clk_sync[2] & ~r_clk_sync[1];
  assign w_mk_rise   = ~r_mk_sync[2] & r_mk_sync[1];
  assign w_word      = {r_shreg[14:0], r_dat_sync[2]};
  assign w_word_done = w_sample && (r_bit_cnt == 4'd15);
  assign w_end_pos   = (r_bit_cnt == 4'd15) && (r_widx == 5'd19) && (r_snum == 6'd63);
  // One-shot: fires only on the step into TIMEOUT, never while the counter sits saturated.
  assign w_timeout   = !w_sample && (r_to_cnt == TO_LAST);
  assign locked      = (r_state == S_LOCK);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_HUNT;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    w_state_nxt   = r_state;
    w_word_strobe = 1'b0;
    w_frame_err   = 1'b0;
    w_hdr_err     = 1'b0;
    case (r_state)
      S_HUNT: begin
        if (w_sample && r_arm) w_state_nxt = S_LOCK;
      end
      S_LOCK: begin
        w_word_strobe = w_word_done;
        w_frame_err   = w_sample && r_arm && !w_end_pos;
`ifdef FRAME_RX_HDR_CHECK_EN
        if (w_word_done && (r_widx == 5'd0) && !w_word[0]) w_hdr_err = 1'b1;
        if (w_word_done && (r_widx == 5'd10) &&
            (w_word[0] || (w_word[15:7] != frm_num))) w_hdr_err = 1'b1;
`endif
        if (w_hdr_err || w_timeout) w_state_nxt = S_HUNT;
      end
      default: w_state_nxt = S_HUNT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mk_sync     <= '0;
      r_clk_sync    <= '0;
      r_dat_sync    <= '0;
      r_shreg       <= '0;
      r_bit_cnt     <= '0;
      r_widx        <= '0;
      r_snum        <= '0;
      r_arm         <= 1'b0;
      r_to_cnt      <= '0;
      r_param_stage <= '0;
      r_param_load  <= 1'b0;
      word_data     <= '0;
      word_valid    <= 1'b0;
      word_idx      <= '0;
      str_num       <= '0;
      frm_num       <= '0;
      params        <= '0;
      param_valid   <= 1'b0;
      err           <= 1'b0;
      err_cnt       <= '0;
    end else begin
      r_mk_sync  <= {r_mk_sync[1:0], MK};
      r_clk_sync <= {r_clk_sync[1:0], CLK};
      r_dat_sync <= {r_dat_sync[1:0], DAT};

      if (w_sample)                r_to_cnt <= '0;
      else if (r_to_cnt != TO_MAX) r_to_cnt <= r_to_cnt + TO_W'(1);

      // A marker coinciding with a sample arms the next bit, not this one.
      if (w_timeout)      r_arm <= 1'b0;
      else if (w_mk_rise) r_arm <= 1'b1;
      else if (w_sample)  r_arm <= 1'b0;

      if (w_timeout) begin
        r_bit_cnt <= '0;
      end else if (w_sample) begin
        r_shreg <= w_word;
        if (r_arm) begin
          r_bit_cnt <= '0;
          r_widx    <= '0;
          r_snum    <= '0;
        end else begin
          r_bit_cnt <= r_bit_cnt + 4'd1;
          if (w_word_strobe) begin
            if (r_widx == 5'd19) begin
              r_widx <= '0;
              r_snum <= r_snum + 6'd1;
            end else begin
              r_widx <= r_widx + 5'd1;
            end
          end
        end
      end

      word_valid <= w_word_strobe;
      if (w_word_strobe) begin
        word_data <= w_word;
        word_idx  <= r_widx;
        str_num   <= r_snum;
        if (r_widx == 5'd0) frm_num <= w_word[15:7];
        // Words 1..7 carry the high nibbles and words 11..17 the low nibbles of {ARU..corr}.
        for (int k = 0; k < 7; k++) begin
          if (r_widx == 5'(k + 1))  r_param_stage[8*k+4 +: 4] <= w_word[3:0];
          if (r_widx == 5'(k + 11)) r_param_stage[8*k   +: 4] <= w_word[3:0];
        end
      end

      r_param_load <= w_word_strobe && (r_widx == 5'd17);
      param_valid  <= r_param_load;
      if (r_param_load) params <= r_param_stage;

      err <= w_frame_err || w_hdr_err;
      if ((w_frame_err || w_hdr_err) && (err_cnt != {ERR_W{1'b1}}))
        err_cnt <= err_cnt + ERR_W'(1);
    end
  end

endmodule

// File: tb/tb_frame_rx.sv
// tb_frame_rx: randomized serial-frame stimulus for frame_rx, scored against a bit-position
// reference model through word/param/err queues drained by an independent monitor.
`timescale 1ns/1ps
module tb_frame_rx;

  localparam int TIMEOUT    = 4096;
  localparam int ERR_W      = 8;
  localparam int CLK_P      = 10;
  localparam int STR_BITS   = 320;
  localparam int FRAME_BITS = 20480;
  localparam int ERR_SAT    = (1 << ERR_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             MK;
  logic             CLK;
  logic             DAT;
  logic [15:0]      word_data;
  logic             word_valid;
  logic [4:0]       word_idx;
  logic [5:0]       str_num;
  logic [8:0]       frm_num;
  logic [55:0]      params;
  logic             param_valid;
  logic             locked;
  logic             err;
  logic [ERR_W-1:0] err_cnt;

  frame_rx #(.TIMEOUT(TIMEOUT), .ERR_W(ERR_W)) dut (
    .clk(clk), .reset(reset), .MK(MK), .CLK(CLK), .DAT(DAT),
    .word_data(word_data), .word_valid(word_valid), .word_idx(word_idx),
    .str_num(str_num), .frm_num(frm_num), .params(params),
    .param_valid(param_valid), .locked(locked), .err(err), .err_cnt(err_cnt)
  );

  always #(CLK_P/2) clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] data;
    logic [4:0]  idx;
    logic [5:0]  str;
    logic [8:0]  frm;
  } word_exp_t;

  word_exp_t        word_q[$];
  logic [55:0]      param_q[$];
  logic [ERR_W-1:0] err_q[$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: position in the frame is a plain bit count since the last marker.
  bit          m_locked;
  int          m_n;
  logic [15:0] m_sh;
  logic [15:0] m_rxw [20];
  logic [8:0]  m_frm;
  int          m_errs;

  function automatic logic [ERR_W-1:0] sat_errs(input int n);
    return (n >= ERR_SAT) ? ERR_W'(ERR_SAT) : ERR_W'(n);
  endfunction

  function automatic logic [55:0] model_params();
    logic [55:0] p = '0;
    for (int k = 0; k < 7; k++) p[8*k +: 8] = {m_rxw[1+k][3:0], m_rxw[11+k][3:0]};
    return p;
  endfunction

  task automatic model_reset();
    m_locked = 1'b0;
    m_n      = 0;
    m_sh     = '0;
    m_frm    = '0;
    m_errs   = 0;
    for (int i = 0; i < 20; i++) m_rxw[i] = '0;
  endtask

  task automatic model_sample(input logic b, input bit mk);
    bit ferr = 1'b0;
    bit herr = 1'b0;
    int idx;
    int str;
    m_sh = {m_sh[14:0], b};
    if (m_locked) begin
      if (m_n % 16 == 15) begin
        idx = (m_n / 16) % 20;
        str = (m_n / STR_BITS) % 64;
        if (idx == 0) m_frm = m_sh[15:7];
        m_rxw[idx] = m_sh;
        word_q.push_back('{m_sh, 5'(idx), 6'(str), m_frm});
        if (idx == 17) param_q.push_back(model_params());
`ifdef FRAME_RX_HDR_CHECK_EN
        if (idx == 0 && m_sh[0] != 1'b1) herr = 1'b1;
        if (idx == 10 && (m_sh[0] != 1'b0 || m_sh[15:7] != m_frm)) herr = 1'b1;
`endif
      end
      if (mk && (m_n % FRAME_BITS) != FRAME_BITS - 1) ferr = 1'b1;
    end
    if (ferr || herr) begin
      m_errs++;
      err_q.push_back(sat_errs(m_errs));
    end
    if (herr)    m_locked = 1'b0;
    else if (mk) m_locked = 1'b1;
    m_n = mk ? 0 : m_n + 1;
  endtask

  int unsigned last_fall_cyc = 0;

  // One serial bit: DAT changes with CLK rising, MK (if requested) rises late in the high phase.
  task automatic send_bit(input logic b, input bit mk);
    int h = int'($urandom_range(5, 4));
    @(negedge clk);
    CLK = 1'b1;
    DAT = b;
    repeat (h - 2) @(negedge clk);
    if (mk) MK = 1'b1;
    repeat (2) @(negedge clk);
    CLK = 1'b0;
    last_fall_cyc = cyc;
    model_sample(b, mk);
    repeat (h) @(negedge clk);
    MK = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) send_bit(w[i], 1'b0);
  endtask

  task automatic send_string(input logic [8:0] frm, input logic bad_hdr, input bit plan_vals,
                             input int n_words);
    logic [15:0] w;
    for (int i = 0; i < n_words; i++) begin
      w = 16'($urandom);
      if (i == 0)  w = {frm, w[6:1], 1'b1};
      if (i == 10) w = {frm, w[6:1], bad_hdr};
      if (plan_vals) begin
        case (i)
          0:  w = 16'h0281;
          1:  w[3:0] = 4'h6;
          11: w[3:0] = 4'h5;
          2:  w[3:0] = 4'h6;
          12: w[3:0] = 4'hF;
          7:  w[3:0] = 4'hA;
          17: w[3:0] = 4'h1;
          default: ;
        endcase
      end
      send_word(w);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_word_data"},   64'(word_data),   64'd0);
    check({tag, "_word_valid"},  64'(word_valid),  64'd0);
    check({tag, "_word_idx"},    64'(word_idx),    64'd0);
    check({tag, "_str_num"},     64'(str_num),     64'd0);
    check({tag, "_frm_num"},     64'(frm_num),     64'd0);
    check({tag, "_params"},      64'(params),      64'd0);
    check({tag, "_param_valid"}, 64'(param_valid), 64'd0);
    check({tag, "_locked"},      64'(locked),      64'd0);
    check({tag, "_err"},         64'(err),         64'd0);
    check({tag, "_err_cnt"},     64'(err_cnt),     64'd0);
  endtask

  // Monitor: drains the scoreboard queues whenever the DUT strobes.
  word_exp_t   mon_w;
  logic [55:0] mon_p;
  int unsigned last17_cyc = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if (word_valid) begin
        if (word_q.size() == 0) begin
          check("word_unexpected", 64'(word_valid), 64'd0);
        end else begin
          mon_w = word_q.pop_front();
          check("word_data", 64'(word_data), 64'(mon_w.data));
          check("word_idx",  64'(word_idx),  64'(mon_w.idx));
          check("str_num",   64'(str_num),   64'(mon_w.str));
          check("frm_num",   64'(frm_num),   64'(mon_w.frm));
        end
        if (word_idx == 5'd17) last17_cyc = cyc;
      end
      if (param_valid) begin
        if (param_q.size() == 0) begin
          check("param_unexpected", 64'(param_valid), 64'd0);
        end else begin
          mon_p = param_q.pop_front();
          check("params", 64'(params), 64'(mon_p));
          check("param_latency", 64'(cyc - last17_cyc), 64'd1);
        end
      end
      if (err) begin
        if (err_q.size() == 0) check("err_unexpected", 64'(err), 64'd0);
        else                   check("err_cnt_at_err", 64'(err_cnt), 64'(err_q.pop_front()));
      end
    end
  end

  initial begin
    #(CLK_P * 120000);
    $display("FAIL watchdog: run exceeded its cycle budget");
    $fatal(1, "watchdog");
  end

  int unsigned fall_cyc;
  int unsigned fall_ref;
  int          waited;

  initial begin
    reset = 1'b1;
    MK    = 1'b0;
    CLK   = 1'b0;
    DAT   = 1'b0;
    model_reset();

    // Serial lines toggle during reset; nothing may escape.
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      CLK = ~CLK;
      DAT = 1'($urandom);
      MK  = 1'($urandom);
    end
    MK  = 1'b0;
    CLK = 1'b0;
    check_all_zero("reset");
    repeat (4) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // No marker: bits shift, but no strobes and no lock.
    for (int i = 0; i < 40; i++) send_bit(1'($urandom), 1'b0);
    check("hunt_locked", 64'(locked), 64'd0);

    // Lock, then the string carrying the documented header and parameter values.
    send_bit(1'($urandom), 1'b1);
    check("lock_rise", 64'(locked), 64'd1);
    send_string(9'd5, 1'b0, 1'b1, 20);
    check("plan_frm_num", 64'(frm_num),        64'd5);
    check("plan_corr",    64'(params[7:0]),    64'h65);
    check("plan_pel",     64'(params[15:8]),   64'h6F);
    check("plan_aru",     64'(params[55:48]),  64'hA1);
    for (int s = 1; s < 10; s++) send_string(9'd5, 1'b0, 1'b0, 20);

    // Early marker at string 10, word 4 (mid-word).
    send_string(9'd5, 1'b0, 1'b0, 4);
    for (int i = 0; i < 7; i++) send_bit(1'($urandom), 1'b0);
    send_bit(1'($urandom), 1'b1);
    repeat (4) @(negedge clk);
    check("early_err_cnt", 64'(err_cnt), 64'd1);
    check("early_locked",  64'(locked),  64'd1);
    send_string(9'h1A3, 1'b0, 1'b0, 20);
    check("realign_idx", 64'(word_idx), 64'd19);
    check("realign_str", 64'(str_num),  64'd0);

    // Header fault: word 10 LSB set.
    send_string(9'h1A3, 1'b1, 1'b0, 20);
    check("hdr_locked",  64'(locked),  64'(m_locked));
    check("hdr_err_cnt", 64'(err_cnt), 64'(sat_errs(m_errs)));
    send_bit(1'($urandom), 1'b1);
    send_string(9'h0C4, 1'b0, 1'b0, 20);
    check("relock", 64'(locked), 64'd1);

    // Timeout: CLK stays low; lock must drop exactly TIMEOUT cycles after the fall is detected
    // (fall is seen 3 posedges after CLK drops: two synchronizer stages, then the sample edge).
    fall_ref = last_fall_cyc;
    waited   = 0;
    while (locked && waited < TIMEOUT + 64) begin
      @(negedge clk);
      waited++;
    end
    fall_cyc = locked ? 0 : cyc;
    check("timeout_cycle", 64'(fall_cyc), 64'(fall_ref + TIMEOUT + 3));
    m_locked = 1'b0;

    // Saturate the error counter: one relock, then 300 early markers.
    for (int i = 0; i < 301; i++) send_bit(1'($urandom), 1'b1);
    repeat (8) @(negedge clk);
    check("err_sat",   64'(err_cnt), 64'(ERR_SAT));
    check("err_model", 64'(err_cnt), 64'(sat_errs(m_errs)));

    // Reset mid-word while locked, then relock and receive a clean string.
    for (int i = 0; i < 7; i++) send_bit(1'($urandom), 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    check_all_zero("midreset");
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    send_bit(1'($urandom), 1'b1);
    send_string(9'h0F0, 1'b0, 1'b0, 20);
    check("post_reset_frm", 64'(frm_num), 64'h0F0);
    check("post_reset_locked", 64'(locked), 64'd1);

    repeat (20) @(negedge clk);
    check("word_q_drained",  64'(word_q.size()),  64'd0);
    check("param_q_drained", 64'(param_q.size()), 64'd0);
    check("err_q_drained",   64'(err_q.size()),   64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
